// File: rtl/memory_arbiter.sv
// Arbitrates one handshaked single-port memory between instruction fetch and the data port.
// Data wins by default; a starvation counter forces an IF grant, and a watchdog aborts hung transactions.
module memory_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        ifReq,
  input  logic [31:0] ifAddr,
  output logic [31:0] ifRdata,
  output logic        ifReady,
  input  logic        dReq,
  input  logic        dWrite,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  output logic [31:0] dRdata,
  output logic        dReady,
  output logic        stallIF,
  output logic        stallMEM,
  output logic        memReq,
  output logic        memWrite,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata,
  input  logic        memAck,
  output logic        busErr
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} stateT;
  typedef enum logic {OWN_DATA, OWN_IF} ownerT;

  stateT         stateReg, stateNext;
  ownerT         ownerReg, ownerNext;
  logic [SW-1:0] starveCntReg, starveCntNext;
  logic [TW-1:0] toCntReg, toCntNext;
  logic [31:0]   ifRdataReg, ifRdataNext;
  logic [31:0]   dRdataReg, dRdataNext;
  logic          ifReadyReg, ifReadyNext;
  logic          dReadyReg, dReadyNext;
  logic          memWriteReg, memWriteNext;
  logic [31:0]   memAddrReg, memAddrNext;
  logic [31:0]   memWdataReg, memWdataNext;
  logic          busErrReg, busErrNext;
  logic          ifWins;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stateReg     <= IDLE;
      ownerReg     <= OWN_DATA;
      starveCntReg <= '0;
      toCntReg     <= '0;
      ifRdataReg   <= '0;
      dRdataReg    <= '0;
      ifReadyReg   <= 1'b0;
      dReadyReg    <= 1'b0;
      memWriteReg  <= 1'b0;
      memAddrReg   <= '0;
      memWdataReg  <= '0;
      busErrReg    <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      ownerReg     <= ownerNext;
      starveCntReg <= starveCntNext;
      toCntReg     <= toCntNext;
      ifRdataReg   <= ifRdataNext;
      dRdataReg    <= dRdataNext;
      ifReadyReg   <= ifReadyNext;
      dReadyReg    <= dReadyNext;
      memWriteReg  <= memWriteNext;
      memAddrReg   <= memAddrNext;
      memWdataReg  <= memWdataNext;
      busErrReg    <= busErrNext;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    ownerNext     = ownerReg;
    starveCntNext = starveCntReg;
    toCntNext     = toCntReg;
    ifRdataNext   = ifRdataReg;
    dRdataNext    = dRdataReg;
    ifReadyNext   = 1'b0;
    dReadyNext    = 1'b0;
    memWriteNext  = memWriteReg;
    memAddrNext   = memAddrReg;
    memWdataNext  = memWdataReg;
    busErrNext    = busErrReg;
    ifWins        = 1'b0;

    case (stateReg)
      IDLE: begin
        if (ifReq || dReq) begin
          ifWins       = ifReq && (!dReq || (starveCntReg == SW'(STARVE_LIMIT)));
          ownerNext    = ifWins ? OWN_IF : OWN_DATA;
          memAddrNext  = ifWins ? ifAddr : dAddr;
          memWriteNext = ifWins ? 1'b0 : dWrite;
          memWdataNext = ifWins ? 32'd0 : dWdata;
          toCntNext    = '0;
          stateNext    = BUSY;
          if (ifWins)
            starveCntNext = '0;
          else if (ifReq && (starveCntReg != SW'(STARVE_LIMIT)))
            starveCntNext = starveCntReg + 1'b1;
        end
      end
      BUSY: begin
        if (memAck) begin
          if (!memWriteReg) begin
            if (ownerReg == OWN_IF) ifRdataNext = memRdata;
            else                    dRdataNext  = memRdata;
          end
          ifReadyNext = (ownerReg == OWN_IF);
          dReadyNext  = (ownerReg == OWN_DATA);
          stateNext   = RESP;
        end else if (toCntReg == TW'(TIMEOUT - 1)) begin
          // Watchdog abort: complete the handshake with zero data so the pipeline can move on.
          if (ownerReg == OWN_IF) ifRdataNext = 32'd0;
          else                    dRdataNext  = 32'd0;
          ifReadyNext = (ownerReg == OWN_IF);
          dReadyNext  = (ownerReg == OWN_DATA);
          busErrNext  = 1'b1;
          stateNext   = RESP;
        end else begin
          toCntNext = toCntReg + 1'b1;
        end
      end
      RESP: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign memReq   = (stateReg == BUSY);
  assign memWrite = memWriteReg;
  assign memAddr  = memAddrReg;
  assign memWdata = memWdataReg;
  assign ifRdata  = ifRdataReg;
  assign dRdata   = dRdataReg;
  assign ifReady  = ifReadyReg;
  assign dReady   = dReadyReg;
  assign busErr   = busErrReg;
  assign stallIF  = ifReq & ~ifReadyReg;
  assign stallMEM = dReq & ~dReadyReg;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: stimulus pushes expected completions, a monitor pops them on each ready.
// A small behavioural memory answers memReq after a programmable number of wait cycles.
module tb_memory_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 16;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        ifReq = 1'b0;
  logic [31:0] ifAddr = '0;
  logic [31:0] ifRdata;
  logic        ifReady;
  logic        dReq = 1'b0;
  logic        dWrite = 1'b0;
  logic [31:0] dAddr = '0;
  logic [31:0] dWdata = '0;
  logic [31:0] dRdata;
  logic        dReady;
  logic        stallIF;
  logic        stallMEM;
  logic        memReq;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata = '0;
  logic        memAck = 1'b0;
  logic        busErr;

  memory_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetN(resetN),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(ifRdata), .ifReady(ifReady),
    .dReq(dReq), .dWrite(dWrite), .dAddr(dAddr), .dWdata(dWdata),
    .dRdata(dRdata), .dReady(dReady),
    .stallIF(stallIF), .stallMEM(stallMEM),
    .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata), .memAck(memAck), .busErr(busErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        isIf;
    logic [31:0] rdata;
    logic        busErr;
  } expT;

  expT expQ[$];
  int  assertCnt = 0;
  int  failCnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCnt++;
    if (act !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic isIf, input logic [31:0] rdata, input logic err);
    expT e;
    e.isIf = isIf;
    e.rdata = rdata;
    e.busErr = err;
    expQ.push_back(e);
  endtask

  // Behavioural memory: fixed contents, ack after waitCycles stall cycles while enabled.
  int   waitCycles = 0;
  logic ackEnable  = 1'b1;
  int   busyCycles = 0;

  function automatic logic [31:0] memContent(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'h2008_0005;
      32'h0000_0100: return 32'h1111_2222;
      32'h0000_0300: return 32'h3333_4444;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (memReq) begin
        busyCycles++;
        memAck   = ackEnable && (busyCycles > waitCycles);
        memRdata = memContent(memAddr);
      end else begin
        busyCycles = 0;
        memAck     = 1'b0;
        memRdata   = '0;
      end
    end
  end

  // Monitor: every ready pulse must match the oldest expected completion.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (resetN && (ifReady || dReady)) begin
        check("single ready", 32'(ifReady & dReady), 32'd0);
        if (expQ.size() == 0) begin
          assertCnt++;
          failCnt++;
          $display("FAIL unexpected ready: ifReady=%0b dReady=%0b, expected no completion", ifReady, dReady);
        end else begin
          e = expQ.pop_front();
          check("ready owner isIf", 32'(ifReady), 32'(e.isIf));
          check("ready rdata", e.isIf ? ifRdata : dRdata, e.rdata);
          check("ready busErr", 32'(busErr), 32'(e.busErr));
          $display("completion %s rdata=0x%08h busErr=%0b", ifReady ? "IF" : "DATA", ifReady ? ifRdata : dRdata, busErr);
        end
      end
    end
  end

  logic [31:0] seenAddr, seenWdata;
  logic        seenWrite;
  int          busyCnt;

  // Runs from the current negedge until both requests are dropped on their ready pulses.
  task automatic serve(input int budget, output int stallIfCnt, output int stallMemCnt);
    logic        prevBusy;
    logic [31:0] pa, pw;
    logic        pwr;
    prevBusy = 1'b0;
    pa = '0; pw = '0; pwr = 1'b0;
    stallIfCnt = 0;
    stallMemCnt = 0;
    busyCnt = 0;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (stallIF)  stallIfCnt++;
      if (stallMEM) stallMemCnt++;
      if (memReq) begin
        if (prevBusy) begin
          check("memAddr stable in BUSY", memAddr, pa);
          check("memWdata stable in BUSY", memWdata, pw);
          check("memWrite stable in BUSY", 32'(memWrite), 32'(pwr));
        end else begin
          seenAddr  = memAddr;
          seenWdata = memWdata;
          seenWrite = memWrite;
        end
        pa = memAddr; pw = memWdata; pwr = memWrite;
        busyCnt++;
      end
      prevBusy = memReq;
      if (ifReady) ifReq = 1'b0;
      if (dReady)  dReq  = 1'b0;
      if (!ifReq && !dReq) return;
      @(negedge clk);
    end
    assertCnt++;
    failCnt++;
    $display("FAIL serve budget: requests still pending after %0d cycles, expected completion", budget);
  endtask

  initial begin
    #300000;
    $display("FAIL global timeout: simulation still running, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int sIf, sMem, dDone, dAtIf;
    // Reset state, sampled while resetN is low.
    #23;
    check("reset memReq", 32'(memReq), 0);
    check("reset ifReady", 32'(ifReady), 0);
    check("reset dReady", 32'(dReady), 0);
    check("reset busErr", 32'(busErr), 0);
    check("reset memWrite", 32'(memWrite), 0);
    check("reset memAddr", memAddr, 0);
    check("reset ifRdata", ifRdata, 0);
    check("reset dRdata", dRdata, 0);
    #4 resetN = 1'b1;

    // IF-only read, zero-wait memory.
    @(negedge clk);
    ifAddr = 32'h40; ifReq = 1'b1;
    pushExp(1'b1, 32'h2008_0005, 1'b0);
    serve(20, sIf, sMem);
    check("t1 stallIF cycles", sIf, 2);
    check("t1 BUSY cycles", busyCnt, 1);
    check("t1 memAddr", seenAddr, 32'h40);
    check("t1 memWrite", 32'(seenWrite), 0);

    // Simultaneous IF and DATA read: DATA first.
    @(negedge clk);
    ifAddr = 32'h40; ifReq = 1'b1;
    dAddr = 32'h100; dWrite = 1'b0; dReq = 1'b1;
    pushExp(1'b0, 32'h1111_2222, 1'b0);
    pushExp(1'b1, 32'h2008_0005, 1'b0);
    serve(30, sIf, sMem);
    check("t2 stallIF cycles", sIf, 5);
    check("t2 stallMEM cycles", sMem, 2);
    check("t2 BUSY cycles", busyCnt, 2);

    // Back-to-back DATA with IF held: starvation forces IF after four DATA grants.
    @(negedge clk);
    for (int k = 0; k < 4; k++) pushExp(1'b0, 32'h3333_4444, 1'b0);
    pushExp(1'b1, 32'h2008_0005, 1'b0);
    pushExp(1'b0, 32'h3333_4444, 1'b0);
    ifAddr = 32'h40; ifReq = 1'b1;
    dAddr = 32'h300; dWrite = 1'b0; dReq = 1'b1;
    dDone = 0; dAtIf = -1;
    for (int i = 0; i < 80 && (ifReq || dReq); i++) begin
      #1;
      if (ifReady) begin ifReq = 1'b0; dAtIf = dDone; end
      if (dReady) begin
        dDone++;
        if (dDone == 5) dReq = 1'b0;
      end
      if (ifReq || dReq) @(negedge clk);
    end
    check("t3 DATA grants before IF", dAtIf, 4);
    check("t3 DATA grants total", dDone, 5);

    // DATA write with three wait cycles; dRdata keeps the last read value.
    @(negedge clk);
    waitCycles = 3;
    dAddr = 32'h200; dWdata = 32'hCAFE_F00D; dWrite = 1'b1; dReq = 1'b1;
    pushExp(1'b0, 32'h3333_4444, 1'b0);
    serve(30, sIf, sMem);
    check("t4 BUSY cycles", busyCnt, 4);
    check("t4 memWrite", 32'(seenWrite), 1);
    check("t4 memAddr", seenAddr, 32'h200);
    check("t4 memWdata", seenWdata, 32'hCAFE_F00D);
    check("t4 stallMEM cycles", sMem, 5);
    waitCycles = 0;
    dWrite = 1'b0;

    // Watchdog abort, then a normal transaction with busErr still set.
    @(negedge clk);
    check("t5 busErr before abort", 32'(busErr), 0);
    ackEnable = 1'b0;
    ifAddr = 32'h40; ifReq = 1'b1;
    pushExp(1'b1, 32'h0, 1'b1);
    serve(40, sIf, sMem);
    check("t5 BUSY cycles to abort", busyCnt, TIMEOUT);
    ackEnable = 1'b1;
    @(negedge clk);
    check("t5 busErr sticky", 32'(busErr), 1);
    dAddr = 32'h100; dReq = 1'b1;
    pushExp(1'b0, 32'h1111_2222, 1'b1);
    serve(20, sIf, sMem);

    // Asynchronous reset in the middle of BUSY drops the transaction silently.
    @(negedge clk);
    ackEnable = 1'b0;
    dAddr = 32'h300; dReq = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #3 resetN = 1'b0;
    #1;
    check("t6 memReq drops on reset", 32'(memReq), 0);
    check("t6 dReady on reset", 32'(dReady), 0);
    check("t6 busErr cleared", 32'(busErr), 0);
    check("t6 memAddr cleared", memAddr, 0);
    check("t6 dRdata cleared", dRdata, 0);
    dReq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 resetN = 1'b1;
    ackEnable = 1'b1;
    @(negedge clk);
    ifAddr = 32'h40; ifReq = 1'b1;
    pushExp(1'b1, 32'h2008_0005, 1'b0);
    serve(20, sIf, sMem);
    check("t6 restart BUSY cycles", busyCnt, 1);

    repeat (4) @(negedge clk);
    check("scoreboard drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
